// File: rtl/flag_stack_pkg.sv
// Shared flag indices, default widths and sizing helpers for the flag register
// and its save/restore LIFO.
package flag_stack_pkg;

  localparam int FLAG_CARRY     = 0;
  localparam int FLAG_SCARRY    = 1;
  localparam int FLAG_GT        = 2;
  localparam int NFLAGS_DEFAULT = 3;

  typedef logic [NFLAGS_DEFAULT-1:0] flag_vec_t;

  // A single-entry LIFO still needs a one-bit address.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/flag_stack_lifo.sv
// Flag save/restore storage: push/pop LIFO with an in-place exchange when push
// and pop coincide on a non-empty stack.
module flag_lifo
  import flag_stack_pkg::*;
#(
  parameter  int W     = NFLAGS_DEFAULT,
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Res,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int AW = idx_width(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [DW-1:0] count_r;
  logic [DW-1:0] count_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic [AW-1:0] top_idx_s;
  logic [AW-1:0] wr_idx_s;
  logic          xchg_s;
  logic          push_only_s;
  logic          pop_only_s;

  // Decode the operation; push+pop on an empty stack degrades to a plain push.
  always_comb begin
    xchg_s      = push & pop & ~empty_r;
    push_only_s = push & ~xchg_s & ~full_r;
    pop_only_s  = pop & ~push & ~empty_r;
    top_idx_s   = AW'(count_r - DW'(1));
    wr_idx_s    = AW'(count_r);
  end

  // Occupancy update; saturation comes from the full/empty gating above.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_only_s, pop_only_s})
      2'b10:   count_nxt_s = count_r + DW'(1);
      2'b01:   count_nxt_s = count_r - DW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy and status registers.
  always_ff @(posedge Clk) begin
    if (Res) begin
      count_r <= {DW{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DW'(DEPTH));
      empty_r <= (count_nxt_s == {DW{1'b0}});
    end
  end

  // Entry storage; contents are deliberately left unreset.
  always_ff @(posedge Clk) begin
    if (xchg_s) begin
      mem_r[top_idx_s] <= wdata;
    end else if (push_only_s) begin
      mem_r[wr_idx_s] <= wdata;
    end
  end

  // Top-of-stack read.
  always_comb begin
    if (empty_r) begin
      rdata = {W{1'b0}};
    end else begin
      rdata = mem_r[top_idx_s];
    end
  end

  assign depth = count_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/flag_stack.sv
// Live ALU condition-flag register with masked clear, optional sticky bits and
// a save/restore LIFO for calls and interrupts.
module flag_stack
  import flag_stack_pkg::*;
#(
  parameter  int                DEPTH       = 4,
  parameter  int                NFLAGS      = NFLAGS_DEFAULT,
  parameter  logic [NFLAGS-1:0] CLEAR_MASK  = 3'b011,
  parameter  logic [NFLAGS-1:0] STICKY_MASK = 3'b000,
  localparam int                DW          = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Res,
  input  logic [NFLAGS-1:0] FlagIn,
  input  logic [NFLAGS-1:0] FlagWe,
  input  logic              Clear,
  input  logic              Push,
  input  logic              Pop,
  output logic [NFLAGS-1:0] Flags,
  output logic [DW-1:0]     Depth,
  output logic              Full,
  output logic              Empty,
  output logic              Ovf,
  output logic              Unf
);

  logic [NFLAGS-1:0] flags_r;
  logic [NFLAGS-1:0] flags_nxt_s;
  logic [NFLAGS-1:0] top_s;
  logic              full_s;
  logic              empty_s;
  logic              pop_ok_s;
  logic              ovf_r;
  logic              unf_r;

  // The stack always saves the registered flags, before this cycle's update.
  flag_lifo #(
    .W     (NFLAGS),
    .DEPTH (DEPTH)
  ) u_lifo (
    .Clk   (Clk),
    .Res   (Res),
    .push  (Push),
    .pop   (Pop),
    .wdata (flags_r),
    .rdata (top_s),
    .depth (Depth),
    .full  (full_s),
    .empty (empty_s)
  );

  // Next live value: restore beats clear, clear beats write, else hold.
  always_comb begin
    pop_ok_s    = Pop & ~empty_s;
    flags_nxt_s = flags_r;
    if (pop_ok_s) begin
      flags_nxt_s = top_s;
    end else begin
      for (int i = 0; i < NFLAGS; i++) begin
        if (Clear && CLEAR_MASK[i]) begin
          flags_nxt_s[i] = 1'b0;
        end else if (FlagWe[i]) begin
          flags_nxt_s[i] = STICKY_MASK[i] ? (flags_r[i] | FlagIn[i]) : FlagIn[i];
        end else begin
          flags_nxt_s[i] = flags_r[i];
        end
      end
    end
  end

  // Live flags and sticky error bits.
  always_ff @(posedge Clk) begin
    if (Res) begin
      flags_r <= {NFLAGS{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      flags_r <= flags_nxt_s;
      ovf_r   <= ovf_r | (Push & ~Pop & full_s);
      unf_r   <= unf_r | (Pop & ~Push & empty_s);
    end
  end

  assign Flags = flags_r;
  assign Full  = full_s;
  assign Empty = empty_s;
  assign Ovf   = ovf_r;
  assign Unf   = unf_r;

endmodule

// File: tb/tb_flag_stack.sv
// Directed bench for flag_stack: default instance plus a sticky-bit0 instance
// driven from the same inputs.
module tb_flag_stack;

  logic       Clk;
  logic       Res;
  logic [2:0] FlagIn;
  logic [2:0] FlagWe;
  logic       Clear;
  logic       Push;
  logic       Pop;

  logic [2:0] flags_a, flags_b;
  logic [2:0] depth_a, depth_b;
  logic       full_a, full_b, empty_a, empty_b;
  logic       ovf_a, ovf_b, unf_a, unf_b;

  int n_cmp = 0;
  int n_mis = 0;

  flag_stack u_dut (
    .Clk(Clk), .Res(Res), .FlagIn(FlagIn), .FlagWe(FlagWe), .Clear(Clear),
    .Push(Push), .Pop(Pop), .Flags(flags_a), .Depth(depth_a), .Full(full_a),
    .Empty(empty_a), .Ovf(ovf_a), .Unf(unf_a)
  );

  flag_stack #(.STICKY_MASK(3'b001)) u_dut_sticky (
    .Clk(Clk), .Res(Res), .FlagIn(FlagIn), .FlagWe(FlagWe), .Clear(Clear),
    .Push(Push), .Pop(Pop), .Flags(flags_b), .Depth(depth_b), .Full(full_b),
    .Empty(empty_b), .Ovf(ovf_b), .Unf(unf_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs, then return to idle just after the edge.
  task automatic cyc(input logic ps, input logic po, input logic cl,
                     input logic [2:0] we, input logic [2:0] din);
    Push = ps; Pop = po; Clear = cl; FlagWe = we; FlagIn = din;
    @(posedge Clk);
    #1;
    Push = 1'b0; Pop = 1'b0; Clear = 1'b0; FlagWe = 3'b000; FlagIn = 3'b000;
  endtask

  logic [2:0] pop_exp [4];

  initial begin
    Res = 1'b1; Push = 1'b0; Pop = 1'b0; Clear = 1'b0; FlagWe = 3'b000; FlagIn = 3'b000;
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b111);
    check("rst_flags", 32'(flags_a), 32'h0);
    check("rst_depth", 32'(depth_a), 32'h0);
    check("rst_empty", 32'(empty_a), 32'h1);
    check("rst_full",  32'(full_a),  32'h0);
    check("rst_ovf",   32'(ovf_a),   32'h0);
    check("rst_unf",   32'(unf_a),   32'h0);
    Res = 1'b0;

    // Plain write
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b101);
    check("wr_flags", 32'(flags_a), 32'h5);
    check("wr_depth", 32'(depth_a), 32'h0);
    check("wr_empty", 32'(empty_a), 32'h1);

    // Masked clear with and without a Gt write
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b111);
    cyc(1'b0, 1'b0, 1'b1, 3'b100, 3'b000);
    check("clr_we", 32'(flags_a), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b111);
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
    check("clr_hold", 32'(flags_a), 32'h4);

    // Round trip; the restore also beats a simultaneous clear and write
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b010);
    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    check("rt_depth1", 32'(depth_a), 32'h1);
    check("rt_empty0", 32'(empty_a), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b101);
    check("rt_wr", 32'(flags_a), 32'h5);
    cyc(1'b0, 1'b1, 1'b1, 3'b111, 3'b000);
    check("rt_pop_flags", 32'(flags_a), 32'h2);
    check("rt_pop_depth", 32'(depth_a), 32'h0);
    check("rt_pop_empty", 32'(empty_a), 32'h1);

    // Fill with 1..4 (each push saves the value before its own write)
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b001);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b010);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b011);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b100);
    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    check("fill_depth", 32'(depth_a), 32'h4);
    check("fill_full",  32'(full_a),  32'h1);
    check("fill_ovf0",  32'(ovf_a),   32'h0);
    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    check("ovf_set",   32'(ovf_a),   32'h1);
    check("ovf_depth", 32'(depth_a), 32'h4);
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b000);
    pop_exp[0] = 3'b100; pop_exp[1] = 3'b011; pop_exp[2] = 3'b010; pop_exp[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
      check($sformatf("pop%0d_flags", k), 32'(flags_a), 32'(pop_exp[k]));
      check($sformatf("pop%0d_depth", k), 32'(depth_a), 32'(3 - k));
    end
    check("drain_empty", 32'(empty_a), 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    check("unf_set",   32'(unf_a),   32'h1);
    check("unf_flags", 32'(flags_a), 32'h1);
    check("unf_depth", 32'(depth_a), 32'h0);
    check("unf_ovf",   32'(ovf_a),   32'h1);

    // Exchange at Depth=2
    Res = 1'b1; cyc(1'b0, 1'b0, 1'b0, 3'b000, 3'b000); Res = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b111);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b001);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b110);
    cyc(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
    check("xchg_flags", 32'(flags_a), 32'h1);
    check("xchg_depth", 32'(depth_a), 32'h2);
    cyc(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    check("xchg_newtop", 32'(flags_a), 32'h6);
    cyc(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    check("xchg_below", 32'(flags_a), 32'h7);

    // Exchange at Full must not flag overflow
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b001);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b010);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b011);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b100);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b101);
    check("xf_full", 32'(full_a), 32'h1);
    cyc(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
    check("xf_flags", 32'(flags_a), 32'h4);
    check("xf_depth", 32'(depth_a), 32'h4);
    check("xf_ovf",   32'(ovf_a),   32'h0);
    cyc(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    check("xf_newtop", 32'(flags_a), 32'h5);
    check("xf_depth3", 32'(depth_a), 32'h3);

    // Push+Pop on empty behaves as a push, no underflow
    Res = 1'b1; cyc(1'b0, 1'b0, 1'b0, 3'b000, 3'b000); Res = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b011);
    cyc(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
    check("pp_empty_depth", 32'(depth_a), 32'h1);
    check("pp_empty_flags", 32'(flags_a), 32'h3);
    check("pp_empty_unf",   32'(unf_a),   32'h0);
    cyc(1'b0, 1'b1, 1'b0, 3'b111, 3'b000);
    check("pp_empty_pop", 32'(flags_a), 32'h3);

    // Sticky bit0 on the second instance
    Res = 1'b1; cyc(1'b0, 1'b0, 1'b0, 3'b000, 3'b000); Res = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 3'b001, 3'b001);
    cyc(1'b0, 1'b0, 1'b0, 3'b001, 3'b000);
    check("sticky_b", 32'(flags_b), 32'h1);
    check("nonsticky_a", 32'(flags_a), 32'h0);

    // Reset mid-stack overrides a concurrent push and write
    cyc(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    check("pre_unf", 32'(unf_a), 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    check("mid_depth3", 32'(depth_b), 32'h3);
    Res = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b111);
    Res = 1'b0;
    check("mid_rst_depth", 32'(depth_b), 32'h0);
    check("mid_rst_flags", 32'(flags_b), 32'h0);
    check("mid_rst_empty", 32'(empty_b), 32'h1);
    check("mid_rst_unf",   32'(unf_a),   32'h0);
    check("mid_rst_ovf",   32'(ovf_b),   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
